// File: rtl/pulse_pattern_tx.sv
// pulse_pattern_tx: single-line pulse-pattern transmitter.
// A small FIFO of (level, length) segments is replayed on output_1 back-to-back;
// the line rests at IDLE_LEVEL whenever nothing is playing.
module pulse_pattern_tx #(
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                          clck,
    input  logic                          rst_n,
    input  logic                          seg_valid,
    output logic                          seg_ready,
    input  logic                          seg_level,
    input  logic [LEN_W-1:0]              seg_len,
    input  logic                          abort,
    output logic                          output_1,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StIdle, StPlay} state_e;

    state_e               state;
    logic [LEN_W-1:0]     cnt;
    logic [LEN_W:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 playing_next;
    logic [CW-1:0]        count_next;
    logic [LEN_W:0]       head;

    // Handshake, pop decision and next occupancy, all from pre-edge state
    always_comb begin
        fifo_full    = (fifo_count == CW'(FIFO_DEPTH));
        fifo_empty   = (fifo_count == '0);
        seg_ready    = !fifo_full && !abort;
        push         = seg_valid && seg_ready;
        // The playback slot frees up when idle or on the last cycle of a segment
        pop          = !abort && !fifo_empty && ((state == StIdle) || (cnt == '0));
        playing_next = !abort && (pop || ((state == StPlay) && (cnt != '0)));
        head         = mem[rd_ptr];
        count_next   = fifo_count;
        if (abort) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = fifo_count + CW'(1);
                2'b01:   count_next = fifo_count - CW'(1);
                default: count_next = fifo_count;
            endcase
        end
    end

    // Segment queue: circular buffer, pointers wrap naturally at power-of-two depth
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {seg_level, seg_len};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
        end
    end

    // Playback FSM with registered line and busy outputs
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= '0;
            output_1 <= IDLE_LEVEL;
            busy     <= 1'b0;
        end else if (abort) begin
            state    <= StIdle;
            cnt      <= '0;
            output_1 <= IDLE_LEVEL;
            busy     <= 1'b0;
        end else begin
            busy <= playing_next || (count_next != '0);
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        state    <= StPlay;
                        cnt      <= head[LEN_W-1:0];
                        output_1 <= head[LEN_W];
                    end
                end
                StPlay: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LEN_W'(1);
                    end else if (pop) begin
                        cnt      <= head[LEN_W-1:0];
                        output_1 <= head[LEN_W];
                    end else begin
                        state    <= StIdle;
                        output_1 <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state    <= StIdle;
                    output_1 <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
